// File: rtl/sprite_plotter.sv
// Sprite plotter: scans a 16x16 key sprite from the ROM, realigns the ROM colour
// with its screen coordinates and emits clipped, colour-keyed VGA pixel writes.
module sprite_plotter #(
  parameter int unsigned ROM_LAT     = 2,
  parameter logic [2:0]  TRANSPARENT = 3'b000,
  parameter int unsigned SCR_W       = 160,
  parameter int unsigned SCR_H       = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] locx,
  input  logic [7:0] locy,
  input  logic [1:0] key_id,
  input  logic [2:0] frame,
  input  logic [2:0] colour_in,
  output logic [3:0] i,
  output logic [5:0] j,
  output logic [2:0] id,
  output logic [1:0] id2,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  // The x/y/colour output register is the final stage of the ROM_LAT-deep line.
  localparam int unsigned DLY        = ROM_LAT - 1;
  localparam logic [8:0]  SCR_W9     = 9'(SCR_W);
  localparam logic [8:0]  SCR_H9     = 9'(SCR_H);
  localparam logic [3:0]  DRAIN_LAST = 4'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] loc_x_r;
  logic [7:0] loc_y_r;
  logic [3:0] drain_cnt_r;
  logic       scan_last_s;
  logic       push_v_s;
  logic [8:0] push_x_s;
  logic [8:0] push_y_s;
  logic       pix_ok_s;
  logic       pipe_v_r [DLY];
  logic [8:0] pipe_x_r [DLY];
  logic [8:0] pipe_y_r [DLY];

  assign scan_last_s = (i == 4'd15) && (j == 6'd15);
  assign push_v_s    = (state_r == ST_SCAN);
  assign push_x_s    = {1'b0, loc_x_r} + {5'b0_0000, i};
  assign push_y_s    = {1'b0, loc_y_r} + {3'b000, j};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_SCAN;
        else       next_state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (scan_last_s) next_state_s = ST_DRAIN;
        else             next_state_s = ST_SCAN;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) next_state_s = ST_FIN;
        else                           next_state_s = ST_DRAIN;
      end
      ST_FIN:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Request latch, ROM address scan and drain counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loc_x_r     <= 8'd0;
      loc_y_r     <= 8'd0;
      id          <= 3'd0;
      id2         <= 2'd0;
      i           <= 4'd0;
      j           <= 6'd0;
      drain_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            loc_x_r <= locx;
            loc_y_r <= locy;
            id      <= frame;
            id2     <= key_id;
            i       <= 4'd0;
            j       <= 6'd0;
          end
          drain_cnt_r <= 4'd0;
        end
        ST_SCAN: begin
          i <= i + 4'd1;
          if (scan_last_s)      j <= 6'd0;
          else if (i == 4'd15)  j <= j + 6'd1;
          else                  j <= j;
          drain_cnt_r <= 4'd0;
        end
        ST_DRAIN: drain_cnt_r <= drain_cnt_r + 4'd1;
        default:  drain_cnt_r <= 4'd0;
      endcase
    end
  end

  // Coordinate delay line matching the ROM read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DLY; k++) begin
        pipe_v_r[k] <= 1'b0;
        pipe_x_r[k] <= 9'd0;
        pipe_y_r[k] <= 9'd0;
      end
    end else begin
      pipe_v_r[0] <= push_v_s;
      pipe_x_r[0] <= push_x_s;
      pipe_y_r[0] <= push_y_s;
      for (int k = 1; k < DLY; k++) begin
        pipe_v_r[k] <= pipe_v_r[k-1];
        pipe_x_r[k] <= pipe_x_r[k-1];
        pipe_y_r[k] <= pipe_y_r[k-1];
      end
    end
  end

  // Visibility test on the 9-bit sums, so off-screen pixels never wrap back on.
  always_comb begin
    pix_ok_s = 1'b0;
    if (pipe_v_r[DLY-1] && (pipe_x_r[DLY-1] < SCR_W9) &&
        (pipe_y_r[DLY-1] < SCR_H9) && (colour_in != TRANSPARENT)) begin
      pix_ok_s = 1'b1;
    end else begin
      pix_ok_s = 1'b0;
    end
  end

  // Registered VGA write and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= pix_ok_s;
      if (pix_ok_s) begin
        x      <= pipe_x_r[DLY-1][7:0];
        y      <= pipe_y_r[DLY-1][6:0];
        colour <= colour_in;
      end
      busy <= (next_state_s == ST_SCAN) || (next_state_s == ST_DRAIN);
      done <= (next_state_s == ST_FIN);
    end
  end

endmodule
